tmds_encoder_array: RTL and testbench
=====================================

TMDS_ENCODER_ARRAY -- requirements
Module: tmds_encoder_array

Interface
REQ-001 Parameter NUM_CH, default 3, sets the number of TMDS channels; the legal range is 1..8.
REQ-002 Parameter LATENCY, default 1, sets the number of input-to-tmds register stages; the legal range is 1..4.
REQ-003 Port clk_pixel, input, 1 bit: the single pixel clock; all state is on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port video_data, input, 8*NUM_CH bits: channel k uses bits [8k+7:8k].
REQ-006 Port island_data, input, 4*NUM_CH bits: channel k uses bits [4k+3:4k].
REQ-007 Port control_data, input, 2*NUM_CH bits: channel k uses bits [2k+1:2k].
REQ-008 Port mode, input, 3 bits, shared by all channels: 0 control, 1 video, 2 video guard, 3 island, 4 island guard, 5-7 treated as 0.
REQ-009 Port seq_clear, input, 1 bit: synchronous clear of seq_error.
REQ-010 Port tmds, output, 10*NUM_CH bits: encoded symbols, with channel k on bits [10k+9:10k].
REQ-011 Port disparity, output, 5*NUM_CH bits: signed two's-complement running disparity of each channel.
REQ-012 Port seq_error, output, 1 bit: sticky period-sequence violation flag.

Function
REQ-013 Channel k SHALL use role r = k mod 3 for guard-band selection.
REQ-014 Mode 0 SHALL map control_data 00/01/10/11 to 1101010100/0010101011/0101010100/1010101011.
REQ-015 Mode 1 SHALL apply HDMI 1.4a 8b/10b encoding:
- transition minimisation: XNOR when N1 > 4, or when N1 == 4 and d[0] == 0; otherwise XOR;
- DC balancing against the channel's accumulator.
REQ-016 Mode 2 SHALL output 1011001100 for roles 0 and 2, and 0100110011 for role 1.
REQ-017 Mode 3 SHALL output the HDMI 1.4a TERC4 code of island_data (e.g. 0000->1010011100, 1010->0110011100).
REQ-018 Mode 4 SHALL output 0100110011 for roles 1 and 2, and TERC4({2'b11, control_data}) for role 0.
REQ-019 The accumulator SHALL update as acc + acc_add (5-bit signed, wrap permitted) on every cycle with mode == 1, and SHALL load 0 on any other cycle.
REQ-020 disparity SHALL equal the accumulator value one cycle after the sampled input.
REQ-021 The tmds symbol for inputs sampled at edge n SHALL appear after edge n+LATENCY-1 (LATENCY=1: registered once).
REQ-022 The encode stage SHALL be combinational into the first register; extra stages SHALL be pure delay.
REQ-023 The pipeline SHALL accept a new input on every cycle, with no stalls.
REQ-024 The sequence checker FSM SHALL have states CTRL, VG1, VG2, VID, IGL1, IGL2, ISL, IGT1, IGT2.
REQ-025 Legal checker transitions SHALL be:
- CTRL->VG1 on mode 2; VG1->VG2 on 2; VG2->VID on 1; VID->VID on 1; VID->CTRL on 0;
- CTRL->IGL1 on 4; IGL1->IGL2 on 4; IGL2->ISL on 3; ISL->ISL on 3; ISL->IGT1 on 4; IGT1->IGT2 on 4;
- IGT2->CTRL on 0; IGT2->IGL1 on 4 (back-to-back island);
- CTRL->CTRL on 0.
REQ-026 Any other mode in any state SHALL set seq_error and move the FSM to the resync state for the current mode: 0->CTRL, 1->VID, 2->VG1, 3->ISL, 4->IGL1.
REQ-027 seq_clear together with a violation on the same cycle SHALL leave seq_error=1 (set wins).

Reset
REQ-028 Asserting reset SHALL immediately force every tmds channel to 1101010100, every disparity to 0, every pipeline stage to 1101010100, seq_error to 0 and the FSM to CTRL.
REQ-029 Reset asserted mid-video SHALL discard all in-flight symbols; the first post-release sample SHALL start from acc 0.

Configuration
REQ-030 Macro TMDS_SEQ_CHECK_EN: when defined, the FSM and seq_error SHALL be implemented as in REQ-024..027.
REQ-031 When TMDS_SEQ_CHECK_EN is undefined, no FSM SHALL be built, seq_error SHALL be tied 0 and seq_clear SHALL be ignored; encoding SHALL be unchanged.

Verification
REQ-032 The bench SHALL cover:
- Reset pulse during mode 1 -> all tmds = 1101010100, disparity = 0, seq_error = 0, asynchronously.
- NUM_CH=3, LATENCY=1, mode 0, control_data ch0 = 01 -> ch0 tmds = 0010101011 one edge later.
- Mode 1, video 0x00 for two cycles from acc 0 -> tmds 0100000000 then 1111111111; disparity -8 then 2.
- Mode 4,4,3(island_data ch0 = 1010),4,4,0 -> ch0 tmds 1010001110 x2 (control_data 00), 0110011100, guard x2; seq_error stays 0.
- Mode 0,2,1 (single guard) -> seq_error = 1; seq_clear alone -> 0; seq_clear with a violation -> stays 1; with macro undefined -> always 0.
- LATENCY=3: same stimulus as the control case -> identical symbols delayed by exactly 2 extra cycles.

Source files
------------

// File: rtl/tmds_encoder_array.sv
// NUM_CH-lane HDMI TMDS/TERC4 encoder: one symbol per lane per pixel clock, LATENCY register stages, never stalls.
// Defining TMDS_SEQ_CHECK_EN builds the period-sequence checker behind seq_error; otherwise seq_error is tied low.
module tmds_encoder_array #(
  parameter int NUM_CH  = 3,
  parameter int LATENCY = 1
) (
  input  logic                 clk_pixel,
  input  logic                 reset,
  input  logic [8*NUM_CH-1:0]  video_data,
  input  logic [4*NUM_CH-1:0]  island_data,
  input  logic [2*NUM_CH-1:0]  control_data,
  input  logic [2:0]           mode,
  input  logic                 seq_clear,
  output logic [10*NUM_CH-1:0] tmds,
  output logic [5*NUM_CH-1:0]  disparity,
  output logic                 seq_error
);

  localparam logic [9:0] SYM_IDLE = 10'b1101010100;
  localparam logic [9:0] SYM_GB_A = 10'b1011001100;
  localparam logic [9:0] SYM_GB_B = 10'b0100110011;

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  function automatic logic [9:0] terc4(input logic [3:0] d);
    case (d)
      4'h0:    return 10'b1010011100;
      4'h1:    return 10'b1001100011;
      4'h2:    return 10'b1011100100;
      4'h3:    return 10'b1011100010;
      4'h4:    return 10'b0101110001;
      4'h5:    return 10'b0100011110;
      4'h6:    return 10'b0110001110;
      4'h7:    return 10'b0100111100;
      4'h8:    return 10'b1011001100;
      4'h9:    return 10'b0100111001;
      4'hA:    return 10'b0110011100;
      4'hB:    return 10'b1011000110;
      4'hC:    return 10'b1010001110;
      4'hD:    return 10'b1001110001;
      4'hE:    return 10'b0101100011;
      default: return 10'b1011000011;
    endcase
  endfunction

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Reserved modes 5-7 behave exactly like control periods everywhere.
  logic [2:0] mode_n;
  assign mode_n = (mode > 3'd4) ? 3'd0 : mode;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam int ROLE = k % 3;

    logic [7:0]        d;
    logic [8:0]        qm;
    logic [3:0]        n1d;
    logic [3:0]        n1q;
    logic              use_xnor;
    logic signed [5:0] diff6;
    logic signed [4:0] diff;
    logic signed [4:0] acc_add;
    logic signed [4:0] acc_d;
    logic signed [4:0] acc_q;
    logic [9:0]        vid_sym;
    logic [9:0]        sym_d;
    logic [9:0]        pipe_q [LATENCY];

    assign d = video_data[8*k +: 8];

    always_comb begin
      n1d      = ones8(d);
      use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
      qm       = '0;
      qm[0]    = d[0];
      for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8]    = ~use_xnor;
      n1q      = ones8(qm[7:0]);
      // diff is (ones - zeros) of the minimised byte, range -8..8.
      diff6    = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
      diff     = diff6[4:0];

      if ((acc_q == 5'sd0) || (diff == 5'sd0)) begin
        vid_sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        acc_add = qm[8] ? diff : -diff;
      end else if ((!acc_q[4] && (diff > 5'sd0)) || (acc_q[4] && (diff < 5'sd0))) begin
        vid_sym = {1'b1, qm[8], ~qm[7:0]};
        acc_add = -diff + (qm[8] ? 5'sd2 : 5'sd0);
      end else begin
        vid_sym = {1'b0, qm[8], qm[7:0]};
        acc_add = diff - (qm[8] ? 5'sd0 : 5'sd2);
      end

      case (mode_n)
        3'd1:    sym_d = vid_sym;
        3'd2:    sym_d = (ROLE == 1) ? SYM_GB_B : SYM_GB_A;
        3'd3:    sym_d = terc4(island_data[4*k +: 4]);
        3'd4:    sym_d = (ROLE == 0) ? terc4({2'b11, control_data[2*k +: 2]}) : SYM_GB_B;
        default: sym_d = ctrl_sym(control_data[2*k +: 2]);
      endcase

      acc_d = (mode_n == 3'd1) ? (acc_q + acc_add) : 5'sd0;
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
        acc_q <= 5'sd0;
        for (int i = 0; i < LATENCY; i++) pipe_q[i] <= SYM_IDLE;
      end else begin
        acc_q     <= acc_d;
        pipe_q[0] <= sym_d;
        for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign tmds[10*k +: 10]    = pipe_q[LATENCY-1];
    assign disparity[5*k +: 5] = acc_q;
  end

`ifdef TMDS_SEQ_CHECK_EN
  typedef enum logic [3:0] {CTRL, VG1, VG2, VID, IGL1, IGL2, ISL, IGT1, IGT2} seq_state_t;

  seq_state_t state_q;
  seq_state_t state_d;
  logic       viol;
  logic       seq_error_q;
  logic       seq_error_d;

  always_comb begin
    state_d = state_q;
    viol    = 1'b0;
    case (state_q)
      CTRL: begin
        if (mode_n == 3'd0)      state_d = CTRL;
        else if (mode_n == 3'd2) state_d = VG1;
        else if (mode_n == 3'd4) state_d = IGL1;
        else                     viol = 1'b1;
      end
      VG1:  if (mode_n == 3'd2) state_d = VG2;  else viol = 1'b1;
      VG2:  if (mode_n == 3'd1) state_d = VID;  else viol = 1'b1;
      VID: begin
        if (mode_n == 3'd1)      state_d = VID;
        else if (mode_n == 3'd0) state_d = CTRL;
        else                     viol = 1'b1;
      end
      IGL1: if (mode_n == 3'd4) state_d = IGL2; else viol = 1'b1;
      IGL2: if (mode_n == 3'd3) state_d = ISL;  else viol = 1'b1;
      ISL: begin
        if (mode_n == 3'd3)      state_d = ISL;
        else if (mode_n == 3'd4) state_d = IGT1;
        else                     viol = 1'b1;
      end
      IGT1: if (mode_n == 3'd4) state_d = IGT2; else viol = 1'b1;
      IGT2: begin
        if (mode_n == 3'd0)      state_d = CTRL;
        else if (mode_n == 3'd4) state_d = IGL1;
        else                     viol = 1'b1;
      end
      default: viol = 1'b1;
    endcase

    // On a violation, resynchronise to the state the current mode most plausibly belongs to.
    if (viol) begin
      case (mode_n)
        3'd1:    state_d = VID;
        3'd2:    state_d = VG1;
        3'd3:    state_d = ISL;
        3'd4:    state_d = IGL1;
        default: state_d = CTRL;
      endcase
    end

    seq_error_d = viol | (seq_error_q & ~seq_clear);
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state_q     <= CTRL;
      seq_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      seq_error_q <= seq_error_d;
    end
  end

  assign seq_error = seq_error_q;
`else
  logic unused_seq_clear;
  assign unused_seq_clear = seq_clear;
  assign seq_error        = 1'b0;
`endif

endmodule

// File: tb/tb_tmds_encoder_array.sv
// Bench for tmds_encoder_array: LATENCY=1 and LATENCY=3 instances share stimulus; expected symbols go through scoreboard queues.
module tb_tmds_encoder_array;

  logic        clk_pixel = 1'b0;
  logic        reset;
  logic [23:0] video_data;
  logic [11:0] island_data;
  logic [5:0]  control_data;
  logic [2:0]  mode;
  logic        seq_clear;
  logic [29:0] tmds1, tmds3;
  logic [14:0] disp1, disp3;
  logic        err1, err3;

  int total = 0;
  int bad   = 0;

  localparam logic [9:0] IDLE = 10'b1101010100;
  localparam logic [9:0] GB_A = 10'b1011001100;
  localparam logic [9:0] GB_B = 10'b0100110011;
`ifdef TMDS_SEQ_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  typedef struct {
    logic [29:0] tmds;
    logic [14:0] disp;
  } exp_t;

  typedef struct {
    int          due;
    logic [29:0] tmds;
  } lat_t;

  exp_t sb[$];
  lat_t sb3[$];

  always #5 clk_pixel = ~clk_pixel;

  tmds_encoder_array #(.NUM_CH(3), .LATENCY(1)) dut1 (
    .clk_pixel(clk_pixel), .reset(reset), .video_data(video_data),
    .island_data(island_data), .control_data(control_data), .mode(mode),
    .seq_clear(seq_clear), .tmds(tmds1), .disparity(disp1), .seq_error(err1)
  );

  tmds_encoder_array #(.NUM_CH(3), .LATENCY(3)) dut3 (
    .clk_pixel(clk_pixel), .reset(reset), .video_data(video_data),
    .island_data(island_data), .control_data(control_data), .mode(mode),
    .seq_clear(seq_clear), .tmds(tmds3), .disparity(disp3), .seq_error(err3)
  );

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  function automatic logic [9:0] terc4_code(input logic [3:0] d);
    case (d)
      4'h0: return 10'b1010011100;  4'h1: return 10'b1001100011;
      4'h2: return 10'b1011100100;  4'h3: return 10'b1011100010;
      4'h4: return 10'b0101110001;  4'h5: return 10'b0100011110;
      4'h6: return 10'b0110001110;  4'h7: return 10'b0100111100;
      4'h8: return 10'b1011001100;  4'h9: return 10'b0100111001;
      4'hA: return 10'b0110011100;  4'hB: return 10'b1011000110;
      4'hC: return 10'b1010001110;  4'hD: return 10'b1001110001;
      4'hE: return 10'b0101100011;  default: return 10'b1011000011;
    endcase
  endfunction

  // Reference 8b/10b video encoder working on plain integer counts.
  function automatic void video_model(input logic [7:0] d, input int acc,
                                      output logic [9:0] q, output int acc_n);
    int         n1, n1q, n0q;
    logic       xn;
    logic [8:0] qm;
    logic [4:0] w;
    n1 = 0;
    for (int i = 0; i < 8; i++) n1 += int'(d[i]);
    xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    n1q = 0;
    for (int i = 0; i < 8; i++) n1q += int'(qm[i]);
    n0q = 8 - n1q;
    if (acc == 0 || n1q == n0q) begin
      q     = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      acc_n = acc + (qm[8] ? (n1q - n0q) : (n0q - n1q));
    end else if ((acc > 0 && n1q > n0q) || (acc < 0 && n0q > n1q)) begin
      q     = {1'b1, qm[8], ~qm[7:0]};
      acc_n = acc + 2 * int'(qm[8]) + n0q - n1q;
    end else begin
      q     = {1'b0, qm[8], qm[7:0]};
      acc_n = acc - 2 * int'(!qm[8]) + n1q - n0q;
    end
    w     = acc_n[4:0];
    acc_n = int'($signed(w));
  endfunction

  task automatic step();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; mode = 3'd0; video_data = '0; island_data = '0;
    control_data = '0; seq_clear = 1'b0;
    #1 reset = 1'b1;
    #2;
    total++; if (tmds1 !== {3{IDLE}}) begin bad++; $display("FAIL reset_tmds1: got %b want %b", tmds1, {3{IDLE}}); end
    total++; if (tmds3 !== {3{IDLE}}) begin bad++; $display("FAIL reset_tmds3: got %b want %b", tmds3, {3{IDLE}}); end
    total++; if (disp1 !== 15'd0) begin bad++; $display("FAIL reset_disp: got %h want 0", disp1); end
    total++; if (err1 !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err1); end
    step();
    reset = 1'b0;
    mode  = 3'd1;
    for (int i = 0; i < 3; i++) begin
      video_data = 24'($urandom);
      step();
    end
    #2 reset = 1'b1;
    #1;
    total++; if (tmds1 !== {3{IDLE}}) begin bad++; $display("FAIL async_tmds1: got %b want %b", tmds1, {3{IDLE}}); end
    total++; if (tmds3 !== {3{IDLE}}) begin bad++; $display("FAIL async_tmds3: got %b want %b", tmds3, {3{IDLE}}); end
    total++; if (disp1 !== 15'd0) begin bad++; $display("FAIL async_disp1: got %h want 0", disp1); end
    total++; if (err1 !== 1'b0) begin bad++; $display("FAIL async_err: got %b want 0", err1); end
    step();
    reset = 1'b0;
    begin
      exp_t e;
      video_data = 24'h000000;
      mode       = 3'd1;
      e.tmds = {3{10'b0100000000}};
      e.disp = {3{5'b11000}};
      sb.push_back(e);
      step();
      e = sb.pop_front();
      total++; if (tmds1 !== e.tmds) begin bad++; $display("FAIL post_reset_tmds: got %b want %b", tmds1, e.tmds); end
      total++; if (disp1 !== e.disp) begin bad++; $display("FAIL post_reset_disp: got %b want %b", disp1, e.disp); end
    end
    mode = 3'd0; seq_clear = 1'b1;
    step();
    seq_clear = 1'b0;
    total++; if (err1 !== 1'b0) begin bad++; $display("FAIL post_reset_clear: got %b want 0", err1); end
  endtask

  task automatic test_control();
    int   modes [6] = '{0, 0, 0, 0, 5, 7};
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      logic [1:0] c0, c1, c2;
      c0 = 2'(i % 4); c1 = 2'((i + 1) % 4); c2 = 2'((i + 2) % 4);
      mode         = 3'(modes[i]);
      control_data = {c2, c1, c0};
      e.tmds = {ctrl_code(c2), ctrl_code(c1), ctrl_code(c0)};
      e.disp = '0;
      sb.push_back(e);
      step();
      e = sb.pop_front();
      total++; if (tmds1 !== e.tmds) begin bad++; $display("FAIL control_tmds[%0d]: got %b want %b", i, tmds1, e.tmds); end
      total++; if (disp1 !== e.disp) begin bad++; $display("FAIL control_disp[%0d]: got %h want %h", i, disp1, e.disp); end
    end
    control_data = '0;
  endtask

  task automatic test_island();
    int   modes [12] = '{4, 4, 3, 4, 4, 4, 4, 3, 3, 4, 4, 0};
    exp_t e;
    control_data = '0;
    island_data  = {4'h0, 4'h0, 4'hA};
    for (int i = 0; i < 12; i++) begin
      mode = 3'(modes[i]);
      case (modes[i])
        4:       e.tmds = {GB_B, GB_B, 10'b1010001110};
        3:       e.tmds = {terc4_code(4'h0), terc4_code(4'h0), 10'b0110011100};
        default: e.tmds = {3{IDLE}};
      endcase
      e.disp = '0;
      sb.push_back(e);
      step();
      e = sb.pop_front();
      total++; if (tmds1 !== e.tmds) begin bad++; $display("FAIL island_tmds[%0d]: got %b want %b", i, tmds1, e.tmds); end
      total++; if (disp1 !== e.disp) begin bad++; $display("FAIL island_disp[%0d]: got %h want %h", i, disp1, e.disp); end
    end
    total++; if (err1 !== 1'b0) begin bad++; $display("FAIL island_seq_err: got %b want 0", err1); end
    island_data = '0;
  endtask

  task automatic test_video_basic();
    int   modes [5] = '{2, 2, 1, 1, 0};
    exp_t e;
    video_data = 24'h000000;
    for (int i = 0; i < 5; i++) begin
      mode   = 3'(modes[i]);
      e.disp = '0;
      case (i)
        0, 1:    e.tmds = {GB_A, GB_B, GB_A};
        2:       begin e.tmds = {3{10'b0100000000}}; e.disp = {3{5'b11000}}; end
        3:       begin e.tmds = {3{10'b1111111111}}; e.disp = {3{5'b00010}}; end
        default: e.tmds = {3{IDLE}};
      endcase
      sb.push_back(e);
      step();
      e = sb.pop_front();
      total++; if (tmds1 !== e.tmds) begin bad++; $display("FAIL video_tmds[%0d]: got %b want %b", i, tmds1, e.tmds); end
      total++; if (disp1 !== e.disp) begin bad++; $display("FAIL video_disp[%0d]: got %b want %b", i, disp1, e.disp); end
    end
    total++; if (err1 !== 1'b0) begin bad++; $display("FAIL video_seq_err: got %b want 0", err1); end
  endtask

  task automatic test_video_random();
    int          acc [3] = '{0, 0, 0};
    logic [23:0] fixed [4] = '{24'h0F_F0_FF, 24'h55_AA_10, 24'h3C_81_E7, 24'h01_FE_80};
    exp_t        e;
    for (int i = 0; i < 28; i++) begin
      if (i < 2) begin
        mode       = 3'd2;
        video_data = 24'($urandom);
        e.tmds     = {GB_A, GB_B, GB_A};
        e.disp     = '0;
      end else begin
        mode       = 3'd1;
        video_data = (i < 6) ? fixed[i-2] : 24'($urandom);
        for (int k = 0; k < 3; k++) begin
          logic [9:0] q;
          int         an;
          logic [31:0] av;
          video_model(video_data[8*k +: 8], acc[k], q, an);
          acc[k] = an;
          av     = an;
          e.tmds[10*k +: 10] = q;
          e.disp[5*k +: 5]   = av[4:0];
        end
      end
      sb.push_back(e);
      step();
      e = sb.pop_front();
      total++; if (tmds1 !== e.tmds) begin bad++; $display("FAIL vrand_tmds[%0d]: got %b want %b", i, tmds1, e.tmds); end
      total++; if (disp1 !== e.disp) begin bad++; $display("FAIL vrand_disp[%0d]: got %b want %b", i, disp1, e.disp); end
    end
    mode = 3'd0;
    step();
    total++; if (disp1 !== 15'd0) begin bad++; $display("FAIL vrand_disp_cleared: got %h want 0", disp1); end
  endtask

  task automatic test_seq_check();
    mode = 3'd0; seq_clear = 1'b0;
    step();
    mode = 3'd2; step();
    mode = 3'd1; step();
    total++; if (err1 !== ERR_EXP) begin bad++; $display("FAIL seq_single_guard: got %b want %b", err1, ERR_EXP); end
    total++; if (err3 !== ERR_EXP) begin bad++; $display("FAIL seq_single_guard_l3: got %b want %b", err3, ERR_EXP); end
    mode = 3'd1; step();
    total++; if (err1 !== ERR_EXP) begin bad++; $display("FAIL seq_sticky: got %b want %b", err1, ERR_EXP); end
    mode = 3'd0; seq_clear = 1'b1; step();
    total++; if (err1 !== 1'b0) begin bad++; $display("FAIL seq_clear: got %b want 0", err1); end
    mode = 3'd3; seq_clear = 1'b1; step();
    total++; if (err1 !== ERR_EXP) begin bad++; $display("FAIL seq_set_wins: got %b want %b", err1, ERR_EXP); end
    mode = 3'd3; seq_clear = 1'b1; step();
    total++; if (err1 !== 1'b0) begin bad++; $display("FAIL seq_clear_again: got %b want 0", err1); end
    seq_clear = 1'b0;
    mode = 3'd4; step();
    mode = 3'd4; step();
    mode = 3'd0; step();
    total++; if (err1 !== 1'b0) begin bad++; $display("FAIL seq_legal_exit: got %b want 0", err1); end
  endtask

  task automatic test_latency3();
    int   modes [6] = '{0, 0, 0, 0, 5, 7};
    lat_t l;
    mode = 3'd0; control_data = '0;
    for (int i = 0; i < 3; i++) step();
    l.due = 0; l.tmds = {3{IDLE}}; sb3.push_back(l);
    l.due = 1; l.tmds = {3{IDLE}}; sb3.push_back(l);
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        logic [1:0] c0, c1, c2;
        c0 = 2'(i % 4); c1 = 2'((i + 1) % 4); c2 = 2'((i + 2) % 4);
        mode         = 3'(modes[i]);
        control_data = {c2, c1, c0};
        l.due  = i + 2;
        l.tmds = {ctrl_code(c2), ctrl_code(c1), ctrl_code(c0)};
        sb3.push_back(l);
      end else begin
        mode = 3'd0; control_data = '0;
      end
      step();
      while (sb3.size() > 0 && sb3[0].due == i) begin
        l = sb3.pop_front();
        total++; if (tmds3 !== l.tmds) begin bad++; $display("FAIL lat3_tmds[%0d]: got %b want %b", i, tmds3, l.tmds); end
      end
    end
    total++; if (sb3.size() != 0) begin bad++; $display("FAIL lat3_drain: got %0d pending want 0", sb3.size()); end
  endtask

  initial begin
    test_reset();
    test_control();
    test_island();
    test_video_basic();
    test_video_random();
    test_seq_check();
    test_latency3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
